// File: rtl/gobou_ctrl_seq_pkg.sv
// Shared definitions for the gobou control sequencer.
//   - default widths for neuron/input counts and memory addresses
//   - default latency from out_end to a writable neuron result
//   - FSM state encoding shared by the top level and any checker
package gobou_ctrl_seq_pkg;

  // Width of neuron / input count fields.
  localparam int GOBOU_LWIDTH   = 10;
  // Width of every memory address port.
  localparam int GOBOU_MEMSIZE  = 12;
  // Cycles from out_end to the neuron result being writable (MAC + bias + activation).
  localparam int GOBOU_PIPE_LAT = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/gobou_ctrl_wb_delay.sv
// Write-back delay line for the gobou sequencer.
// Delays each out_end pulse by PIPE_LAT cycles and turns it into a one-cycle
// result write strobe, with the write address stepping from the latched base.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset; discards pending writes
//   start_i  accepted start request; restarts the write counter
//   pulse_i  registered out_end from the accumulate stream
//   base_i   result base address (latched configuration)
//   we_o     registered write strobe
//   addr_o   registered write address (0 when not writing)
//   empty_o  no write is pending in the line (nor entering it this cycle)
// PIPE_LAT must be at least 2: the line holds PIPE_LAT-1 stages and the
// registered strobe supplies the last one.
module gobou_ctrl_wb_delay
  import gobou_ctrl_seq_pkg::*;
#(
  parameter int MEMSIZE  = GOBOU_MEMSIZE,
  parameter int PIPE_LAT = GOBOU_PIPE_LAT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               pulse_i,
  input  logic [MEMSIZE-1:0] base_i,
  output logic               we_o,
  output logic [MEMSIZE-1:0] addr_o,
  output logic               empty_o
);

  logic [PIPE_LAT-2:0] line_q, line_d;
  logic [MEMSIZE-1:0]  wr_cnt_q, wr_cnt_d;
  logic [MEMSIZE-1:0]  addr_q, addr_d;
  logic                we_q, we_d;

  // Registers for the delay line, write counter and write-port outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q   <= {(PIPE_LAT-1){1'b0}};
      wr_cnt_q <= {MEMSIZE{1'b0}};
      addr_q   <= {MEMSIZE{1'b0}};
      we_q     <= 1'b0;
    end else begin
      line_q   <= line_d;
      wr_cnt_q <= wr_cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
    end
  end

  // Shift the pulse along; the oldest stage becomes next cycle's strobe.
  always_comb begin
    line_d    = line_q;
    line_d[0] = pulse_i;
    for (int i = 1; i < PIPE_LAT - 1; i++) begin
      line_d[i] = line_q[i-1];
    end
    we_d = line_q[PIPE_LAT-2];
    if (start_i) begin
      wr_cnt_d = {MEMSIZE{1'b0}};
    end else if (we_d) begin
      wr_cnt_d = wr_cnt_q + MEMSIZE'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (we_d) begin
      addr_d = base_i + wr_cnt_q;
    end else begin
      addr_d = {MEMSIZE{1'b0}};
    end
  end

  // The strobe register itself is not counted: the last write may still be
  // on the port in the cycle the sequencer decides to leave DRAIN.
  assign empty_o = ~pulse_i & ~(|line_q);
  assign we_o    = we_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/gobou_ctrl_seq.sv
// Top-level sequencer for the gobou fully-connected datapath.
// Walks every (output neuron, input) pair, driving input/weight read
// addresses and begin/valid/end framing, then issues delayed write-back
// strobes for finished neurons and reports completion.
// Ports:
//   clk, xrst (synchronous, active-high), req (start pulse, IDLE/DONE only)
//   total_in, total_out, in_offset, w_offset, out_offset: latched on start
//   busy, ack: run status
//   in_addr, w_addr, out_begin, out_valid, out_end: accumulate stream
//   out_we, out_addr: result write-back
// Every output is a register loaded from the next-state values, so a req
// in cycle t shows the first stream element in cycle t+1.
module gobou_ctrl_seq
  import gobou_ctrl_seq_pkg::*;
#(
  parameter int LWIDTH   = GOBOU_LWIDTH,
  parameter int MEMSIZE  = GOBOU_MEMSIZE,
  parameter int PIPE_LAT = GOBOU_PIPE_LAT
) (
  input  logic               clk,
  input  logic               xrst,
  input  logic               req,
  input  logic [LWIDTH-1:0]  total_in,
  input  logic [LWIDTH-1:0]  total_out,
  input  logic [MEMSIZE-1:0] in_offset,
  input  logic [MEMSIZE-1:0] w_offset,
  input  logic [MEMSIZE-1:0] out_offset,
  output logic               busy,
  output logic               ack,
  output logic [MEMSIZE-1:0] in_addr,
  output logic [MEMSIZE-1:0] w_addr,
  output logic               out_begin,
  output logic               out_valid,
  output logic               out_end,
  output logic               out_we,
  output logic [MEMSIZE-1:0] out_addr
);

  state_e state_q, state_d;

  // Latched configuration.
  logic [LWIDTH-1:0]  tin_q, tin_d;
  logic [LWIDTH-1:0]  tout_q, tout_d;
  logic [MEMSIZE-1:0] in_off_q, in_off_d;
  logic [MEMSIZE-1:0] w_off_q, w_off_d;
  logic [MEMSIZE-1:0] out_off_q, out_off_d;

  // Position of the element currently on the stream outputs.
  logic [LWIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic [LWIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [MEMSIZE-1:0] w_ptr_q, w_ptr_d;

  // Registered stream / status outputs.
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic [MEMSIZE-1:0] in_addr_q, in_addr_d;
  logic [MEMSIZE-1:0] w_addr_q, w_addr_d;
  logic               begin_q, begin_d;
  logic               valid_q, valid_d;
  logic               end_q, end_d;

  logic accept_s;
  logic wb_empty_s;

  // State, configuration, counter and output registers.
  always_ff @(posedge clk) begin
    if (xrst) begin
      state_q   <= ST_IDLE;
      tin_q     <= {LWIDTH{1'b0}};
      tout_q    <= {LWIDTH{1'b0}};
      in_off_q  <= {MEMSIZE{1'b0}};
      w_off_q   <= {MEMSIZE{1'b0}};
      out_off_q <= {MEMSIZE{1'b0}};
      in_cnt_q  <= {LWIDTH{1'b0}};
      out_cnt_q <= {LWIDTH{1'b0}};
      w_ptr_q   <= {MEMSIZE{1'b0}};
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      in_addr_q <= {MEMSIZE{1'b0}};
      w_addr_q  <= {MEMSIZE{1'b0}};
      begin_q   <= 1'b0;
      valid_q   <= 1'b0;
      end_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tin_q     <= tin_d;
      tout_q    <= tout_d;
      in_off_q  <= in_off_d;
      w_off_q   <= w_off_d;
      out_off_q <= out_off_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      w_ptr_q   <= w_ptr_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      begin_q   <= begin_d;
      valid_q   <= valid_d;
      end_q     <= end_d;
    end
  end

  // Next state, configuration latch and stream counters.
  always_comb begin
    state_d   = state_q;
    tin_d     = tin_q;
    tout_d    = tout_q;
    in_off_d  = in_off_q;
    w_off_d   = w_off_q;
    out_off_d = out_off_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    w_ptr_d   = w_ptr_q;
    accept_s  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          accept_s  = 1'b1;
          tin_d     = total_in;
          tout_d    = total_out;
          in_off_d  = in_offset;
          w_off_d   = w_offset;
          out_off_d = out_offset;
          in_cnt_d  = {LWIDTH{1'b0}};
          out_cnt_d = {LWIDTH{1'b0}};
          w_ptr_d   = {MEMSIZE{1'b0}};
          // An empty layer completes at once without touching the datapath.
          if ((total_in == {LWIDTH{1'b0}}) || (total_out == {LWIDTH{1'b0}})) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_ACC: begin
        // Weights are stored neuron-major, so a running pointer replaces
        // out_cnt * total_in + in_cnt.
        w_ptr_d = w_ptr_q + MEMSIZE'(1);
        if (in_cnt_q == (tin_q - LWIDTH'(1))) begin
          in_cnt_d  = {LWIDTH{1'b0}};
          out_cnt_d = out_cnt_q + LWIDTH'(1);
          if (out_cnt_q == (tout_q - LWIDTH'(1))) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          in_cnt_d = in_cnt_q + LWIDTH'(1);
          state_d  = ST_ACC;
        end
      end
      ST_DRAIN: begin
        if (wb_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from the next state/counters.
  always_comb begin
    busy_d    = (state_d == ST_ACC) || (state_d == ST_DRAIN);
    ack_d     = (state_d == ST_DONE);
    valid_d   = (state_d == ST_ACC);
    in_addr_d = {MEMSIZE{1'b0}};
    w_addr_d  = {MEMSIZE{1'b0}};
    begin_d   = 1'b0;
    end_d     = 1'b0;
    if (state_d == ST_ACC) begin
      in_addr_d = in_off_d + MEMSIZE'(in_cnt_d);
      w_addr_d  = w_off_d + w_ptr_d;
      begin_d   = (in_cnt_d == {LWIDTH{1'b0}});
      end_d     = (in_cnt_d == (tin_d - LWIDTH'(1)));
    end else begin
      in_addr_d = {MEMSIZE{1'b0}};
      w_addr_d  = {MEMSIZE{1'b0}};
      begin_d   = 1'b0;
      end_d     = 1'b0;
    end
  end

  gobou_ctrl_wb_delay #(
    .MEMSIZE  (MEMSIZE),
    .PIPE_LAT (PIPE_LAT)
  ) u_wb_delay (
    .clk_i   (clk),
    .rst_i   (xrst),
    .start_i (accept_s),
    .pulse_i (end_q),
    .base_i  (out_off_q),
    .we_o    (out_we),
    .addr_o  (out_addr),
    .empty_o (wb_empty_s)
  );

  assign busy      = busy_q;
  assign ack       = ack_q;
  assign in_addr   = in_addr_q;
  assign w_addr    = w_addr_q;
  assign out_begin = begin_q;
  assign out_valid = valid_q;
  assign out_end   = end_q;

endmodule

// File: tb/tb_gobou_ctrl_seq.sv
// Self-checking bench for gobou_ctrl_seq. Expected traces come from the
// stream rules: element k of a run is neuron (k-1)/total_in, input
// (k-1)%total_in; neuron j is written PIPE_LAT cycles after its end cycle.
module tb_gobou_ctrl_seq;

  localparam int LW    = 10;
  localparam int MS    = 12;
  localparam int PL    = 4;
  localparam int AMASK = (1 << MS) - 1;

  logic          clk = 1'b0;
  logic          xrst;
  logic          req;
  logic [LW-1:0] total_in, total_out;
  logic [MS-1:0] in_offset, w_offset, out_offset;
  logic          busy, ack, out_begin, out_valid, out_end, out_we;
  logic [MS-1:0] in_addr, w_addr, out_addr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  gobou_ctrl_seq #(.LWIDTH(LW), .MEMSIZE(MS), .PIPE_LAT(PL)) dut (
    .clk        (clk),
    .xrst       (xrst),
    .req        (req),
    .total_in   (total_in),
    .total_out  (total_out),
    .in_offset  (in_offset),
    .w_offset   (w_offset),
    .out_offset (out_offset),
    .busy       (busy),
    .ack        (ack),
    .in_addr    (in_addr),
    .w_addr     (w_addr),
    .out_begin  (out_begin),
    .out_valid  (out_valid),
    .out_end    (out_end),
    .out_we     (out_we),
    .out_addr   (out_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Every output at rest; ack as given.
  task automatic check_quiet(input string tag, input logic exp_ack);
    chk({tag, ".busy"},  {31'd0, busy},      32'd0);
    chk({tag, ".ack"},   {31'd0, ack},       {31'd0, exp_ack});
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".begin"}, {31'd0, out_begin}, 32'd0);
    chk({tag, ".end"},   {31'd0, out_end},   32'd0);
    chk({tag, ".we"},    {31'd0, out_we},    32'd0);
    chk({tag, ".inad"},  {20'd0, in_addr},   32'd0);
    chk({tag, ".wad"},   {20'd0, w_addr},    32'd0);
    chk({tag, ".oad"},   {20'd0, out_addr},  32'd0);
  endtask

  // Compare cycle k (1 = cycle after req) of a run against the stream rules.
  task automatic check_cycle(input int k, input int tin, input int tout,
                             input int ioff, input int woff, input int ooff);
    int n, d, idx, i, m;
    logic e_valid, e_begin, e_end, e_we, e_busy, e_ack;
    int e_in, e_w, e_oa;
    n = tin * tout;
    d = (n == 0) ? 1 : n + PL + 1;
    e_valid = (k >= 1) && (k <= n);
    e_begin = 1'b0; e_end = 1'b0; e_in = 0; e_w = 0;
    if (e_valid) begin
      idx     = k - 1;
      i       = idx % tin;
      e_in    = (ioff + i) & AMASK;
      e_w     = (woff + idx) & AMASK;
      e_begin = (i == 0);
      e_end   = (i == tin - 1);
    end
    m    = k - PL;
    e_we = (n > 0) && (m >= tin) && (m <= n) && ((m % tin) == 0);
    e_oa = e_we ? ((ooff + m / tin - 1) & AMASK) : 0;
    e_busy = (n > 0) && (k < d);
    e_ack  = (k >= d);
    chk("valid", {31'd0, out_valid}, {31'd0, e_valid});
    chk("begin", {31'd0, out_begin}, {31'd0, e_begin});
    chk("end",   {31'd0, out_end},   {31'd0, e_end});
    chk("we",    {31'd0, out_we},    {31'd0, e_we});
    chk("busy",  {31'd0, busy},      {31'd0, e_busy});
    chk("ack",   {31'd0, ack},       {31'd0, e_ack});
    if (e_valid || e_ack) begin
      chk("in_addr", {20'd0, in_addr}, e_in);
      chk("w_addr",  {20'd0, w_addr},  e_w);
    end
    if (e_we || e_ack) begin
      chk("out_addr", {20'd0, out_addr}, e_oa);
    end
  endtask

  // One run: req, then per-cycle checks through one cycle past completion.
  // inj_at: cycle at which a stray req (with scrambled config) is pulsed.
  // rst_at: cycle at which xrst is raised, aborting the run.
  task automatic run(input int tin, input int tout, input int ioff, input int woff,
                     input int ooff, input int inj_at, input int rst_at);
    int d;
    d = (tin * tout == 0) ? 1 : tin * tout + PL + 1;
    @(negedge clk);
    total_in   = LW'(tin);
    total_out  = LW'(tout);
    in_offset  = MS'(ioff);
    w_offset   = MS'(woff);
    out_offset = MS'(ooff);
    req        = 1'b1;
    @(negedge clk);
    cyc = 1;
    req = 1'b0;
    for (int k = 1; k <= d + 1; k++) begin
      cyc = k;
      check_cycle(k, tin, tout, ioff, woff, ooff);
      if (k == rst_at) begin
        xrst = 1'b1;
        @(negedge clk);
        xrst = 1'b0;
        cyc  = k + 1;
        check_quiet("abort", 1'b0);
        for (int q = 0; q < PL + 2; q++) begin
          @(negedge clk);
          cyc = k + 2 + q;
          check_quiet("abort_hold", 1'b0);
        end
        return;
      end
      if (k == inj_at) begin
        req        = 1'b1;
        total_in   = LW'($urandom_range(1, 7));
        total_out  = LW'($urandom_range(1, 7));
        in_offset  = MS'($urandom);
        w_offset   = MS'($urandom);
        out_offset = MS'($urandom);
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  initial begin
    int tin, tout, d, inj;
    xrst = 1'b1; req = 1'b0;
    total_in = '0; total_out = '0; in_offset = '0; w_offset = '0; out_offset = '0;

    // 1. reset for 3 cycles, then release: everything at rest
    repeat (3) @(negedge clk);
    xrst = 1'b0;
    @(negedge clk);
    check_quiet("reset", 1'b0);

    // 2. nominal 3x2 run
    run(3, 2, 12'h010, 12'h100, 12'h200, -1, -1);
    // 3. single input per neuron
    run(1, 3, 12'h020, 12'h300, 12'h400, -1, -1);
    // 4. empty layer, then a 2x2 run
    run(3, 0, 12'h030, 12'h500, 12'h600, -1, -1);
    run(2, 2, 12'h040, 12'h700, 12'h800, -1, -1);
    // 5. stray req during ACC, then during DRAIN
    run(3, 2, 12'h010, 12'h100, 12'h200, 2, -1);
    run(3, 2, 12'h010, 12'h100, 12'h200, 8, -1);
    // 6. reset at the 4th valid cycle, then a clean run
    run(3, 2, 12'h010, 12'h100, 12'h200, -1, 4);
    run(3, 2, 12'h010, 12'h100, 12'h200, -1, -1);
    // address wrap-around
    run(2, 3, 12'hFFF, 12'hFFD, 12'hFFE, -1, -1);

    // randomized runs
    for (int r = 0; r < 14; r++) begin
      tin  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 4);
      tout = $urandom_range(1, 4);
      d    = (tin * tout == 0) ? 1 : tin * tout + PL + 1;
      inj  = (d >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, d - 1) : -1;
      run(tin, tout, $urandom_range(0, AMASK), $urandom_range(0, AMASK),
          $urandom_range(0, AMASK), inj, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
